pd0_datapath: RTL and testbench

- Small datapath block bundling three independent sub-functions that share one clock and reset.
- Sub-functions: a combinational 4-op ALU with zero/negative flags, a single resettable data register, and a two-register arithmetic pipeline that computes (op1 + op2) - op1.
- Serves as the bring-up datapath for the processor project and as a waveform/flow sanity target.

---
 rtl/pd0_datapath.sv | 110 +++++++++++
 tb/tb_pd0_datapath.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/pd0_datapath.sv
// pd0_datapath: bring-up datapath bundling three independent sub-functions.
//   - Combinational 4-op ALU (ADD/SUB/AND/OR) with zero/negative flags.
//   - Single resettable data register.
//   - Two-stage pipeline computing (op1 + op2) - op1, i.e. returns op2.
// Optional feature: define PD0_ALU_OVF_EN to add alu_ovf_o (signed overflow).
// Ports:
//   clk, rst (async, active-low)
//   alu_sel_i, alu_op1_i, alu_op2_i -> alu_res_o, alu_zero_o, alu_neg_o [, alu_ovf_o]
//   reg_in_i -> reg_out_o
//   tsp_op1_i, tsp_op2_i -> tsp_res_o (2-edge latency)

package pd0_pkg;
   typedef enum logic [1:0] {
      ADD = 2'd0,
      SUB = 2'd1,
      AND = 2'd2,
      OR  = 2'd3
   } alu_op_e;
endpackage

module pd0_datapath #(
   parameter int unsigned DWIDTH = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [1:0]        alu_sel_i,
   input  logic [DWIDTH-1:0] alu_op1_i,
   input  logic [DWIDTH-1:0] alu_op2_i,
   output logic [DWIDTH-1:0] alu_res_o,
   output logic              alu_zero_o,
   output logic              alu_neg_o,
`ifdef PD0_ALU_OVF_EN
   output logic              alu_ovf_o,
`endif
   input  logic [DWIDTH-1:0] reg_in_i,
   output logic [DWIDTH-1:0] reg_out_o,
   input  logic [DWIDTH-1:0] tsp_op1_i,
   input  logic [DWIDTH-1:0] tsp_op2_i,
   output logic [DWIDTH-1:0] tsp_res_o
);
   import pd0_pkg::*;

   localparam int unsigned MSB = DWIDTH - 1;

   logic [DWIDTH-1:0] alu_res_c;
   logic [DWIDTH-1:0] reg_d,  reg_q;
   logic [DWIDTH-1:0] sum_d,  sum_q;
   logic [DWIDTH-1:0] op1_d,  op1_q;
   logic [DWIDTH-1:0] res_d,  res_q;

   // ALU: purely combinational, independent of clk/rst; carries discarded
   always_comb begin
      alu_res_c = '0;
      unique case (alu_op_e'(alu_sel_i))
         ADD: alu_res_c = alu_op1_i + alu_op2_i;
         SUB: alu_res_c = alu_op1_i - alu_op2_i;
         AND: alu_res_c = alu_op1_i & alu_op2_i;
         OR:  alu_res_c = alu_op1_i | alu_op2_i;
         default: alu_res_c = '0;
      endcase
   end

   assign alu_res_o  = alu_res_c;
   assign alu_zero_o = (alu_res_c == '0);
   assign alu_neg_o  = alu_res_c[MSB];

`ifdef PD0_ALU_OVF_EN
   // Signed overflow: result sign disagrees with what the operand signs imply
   logic alu_ovf_c;
   always_comb begin
      alu_ovf_c = 1'b0;
      unique case (alu_op_e'(alu_sel_i))
         ADD: alu_ovf_c = (alu_op1_i[MSB] == alu_op2_i[MSB]) &&
                          (alu_res_c[MSB] != alu_op1_i[MSB]);
         SUB: alu_ovf_c = (alu_op1_i[MSB] != alu_op2_i[MSB]) &&
                          (alu_res_c[MSB] != alu_op1_i[MSB]);
         default: alu_ovf_c = 1'b0;
      endcase
   end
   assign alu_ovf_o = alu_ovf_c;
`endif

   // Next-state for data register and pipeline; widths kept at DWIDTH so the
   // stage-1 sum wraps and stage-2 subtraction unwraps it exactly.
   always_comb begin
      reg_d = reg_in_i;
      sum_d = tsp_op1_i + tsp_op2_i;
      op1_d = tsp_op1_i;
      res_d = sum_q - op1_q;
   end

   // State registers; reset flushes all in-flight pipeline data
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         reg_q <= '0;
         sum_q <= '0;
         op1_q <= '0;
         res_q <= '0;
      end else begin
         reg_q <= reg_d;
         sum_q <= sum_d;
         op1_q <= op1_d;
         res_q <= res_d;
      end
   end

   assign reg_out_o = reg_q;
   assign tsp_res_o = res_q;

endmodule

// File: tb/tb_pd0_datapath.sv
// Directed self-checking bench for pd0_datapath (ALU, register, pipeline).
module tb_pd0_datapath;
   logic       clk = 1'b0;
   logic       rst;
   logic [1:0] alu_sel_i;
   logic [7:0] alu_op1_i, alu_op2_i, alu_res_o;
   logic       alu_zero_o, alu_neg_o;
`ifdef PD0_ALU_OVF_EN
   logic       alu_ovf_o;
`endif
   logic [7:0] reg_in_i, reg_out_o;
   logic [7:0] tsp_op1_i, tsp_op2_i, tsp_res_o;

   int n_cmp = 0;
   int n_err = 0;

   pd0_datapath #(.DWIDTH(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .alu_sel_i  (alu_sel_i),
      .alu_op1_i  (alu_op1_i),
      .alu_op2_i  (alu_op2_i),
      .alu_res_o  (alu_res_o),
      .alu_zero_o (alu_zero_o),
      .alu_neg_o  (alu_neg_o),
`ifdef PD0_ALU_OVF_EN
      .alu_ovf_o  (alu_ovf_o),
`endif
      .reg_in_i   (reg_in_i),
      .reg_out_o  (reg_out_o),
      .tsp_op1_i  (tsp_op1_i),
      .tsp_op2_i  (tsp_op2_i),
      .tsp_res_o  (tsp_res_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic alu(input logic [1:0] sel, input logic [7:0] a, input logic [7:0] b,
                      input string tag, input logic [7:0] r, input logic z, input logic n);
      alu_sel_i = sel; alu_op1_i = a; alu_op2_i = b;
      #1;
      chk({tag, ".res"},  alu_res_o, r);
      chk({tag, ".zero"}, 8'(alu_zero_o), 8'(z));
      chk({tag, ".neg"},  8'(alu_neg_o),  8'(n));
   endtask

   initial begin
      rst = 1'b0;
      alu_sel_i = 2'd0; alu_op1_i = '0; alu_op2_i = '0;
      reg_in_i = '0; tsp_op1_i = '0; tsp_op2_i = '0;
      #3;
      chk("rst.reg", reg_out_o, 8'd0);
      chk("rst.tsp", tsp_res_o, 8'd0);

      // ALU is combinational and works while rst is low
      alu(2'd0, 8'd10,   8'd3,    "add_10_3", 8'd13,  1'b0, 1'b0);
      alu(2'd1, 8'd10,   8'd3,    "sub_10_3", 8'd7,   1'b0, 1'b0);
      alu(2'd1, 8'd3,    8'd10,   "sub_3_10", 8'd249, 1'b0, 1'b1);
      alu(2'd2, 8'hF0,   8'h0F,   "and_f0",   8'h00,  1'b1, 1'b0);
      alu(2'd3, 8'hA5,   8'h5A,   "or_a5",    8'hFF,  1'b0, 1'b1);
`ifdef PD0_ALU_OVF_EN
      alu_sel_i = 2'd0; alu_op1_i = 8'h7F; alu_op2_i = 8'h01; #1;
      chk("ovf.add_7f_01", 8'(alu_ovf_o), 8'd1);
      alu_sel_i = 2'd1; alu_op1_i = 8'h80; alu_op2_i = 8'h01; #1;
      chk("ovf.sub_80_01", 8'(alu_ovf_o), 8'd1);
      alu_sel_i = 2'd0; alu_op1_i = 8'd10; alu_op2_i = 8'd3; #1;
      chk("ovf.add_10_3", 8'(alu_ovf_o), 8'd0);
`endif

      // Register capture after release
      @(negedge clk);
      rst = 1'b1;
      reg_in_i = 8'd9;
      tick;
      chk("reg.9", reg_out_o, 8'd9);
      reg_in_i = 8'd8;
      tick;
      chk("reg.8", reg_out_o, 8'd8);

      // Async reset mid-cycle, held through edges
      #2 rst = 1'b0;
      #1 chk("reg.async", reg_out_o, 8'd0);
      tick;
      chk("reg.hold1", reg_out_o, 8'd0);
      tick;
      chk("reg.hold2", reg_out_o, 8'd0);
      @(negedge clk);
      rst = 1'b1;

      // Pipeline stream: result = op2, two-edge latency
      tsp_op1_i = 8'd5;  tsp_op2_i = 8'd21;
      tick;
      chk("tsp.s0", tsp_res_o, 8'd0);
      tsp_op1_i = 8'd12; tsp_op2_i = 8'd7;
      tick;
      chk("tsp.s21", tsp_res_o, 8'd21);
      tsp_op1_i = 8'd0;  tsp_op2_i = 8'd0;
      tick;
      chk("tsp.s7", tsp_res_o, 8'd7);
      tick;
      chk("tsp.s00", tsp_res_o, 8'd0);

      // Wrap of the stage-1 sum
      tsp_op1_i = 8'd200; tsp_op2_i = 8'd100;
      tick;
      tsp_op1_i = 8'd255; tsp_op2_i = 8'd255;
      tick;
      chk("tsp.wrap100", tsp_res_o, 8'd100);
      tick;
      chk("tsp.wrap255", tsp_res_o, 8'd255);

      // Flush: in-flight (1,55) must never emerge
      tsp_op1_i = 8'd1; tsp_op2_i = 8'd55;
      tick;
      tsp_op1_i = 8'd3; tsp_op2_i = 8'd9;
      rst = 1'b0;
      #1 chk("flush.async", tsp_res_o, 8'd0);
      tick;
      chk("flush.hold", tsp_res_o, 8'd0);
      @(negedge clk);
      rst = 1'b1;
      tick;
      chk("flush.first0", tsp_res_o, 8'd0);
      tick;
      chk("flush.next9", tsp_res_o, 8'd9);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   // Time bound so the run always terminates
   initial begin
      #100000;
      $display("FAIL timeout: observed running expected finished");
      $fatal(1, "timeout");
   end
endmodule
